// File: rtl/digit_column_streamer.sv
// digit_column_streamer
//   Frame sequencer for an N-digit seven-segment style display on an SSD1306.
//   It walks every page, digit and column of the display. For each position it
//   presents the digit's segments and the (column, page) index to an external
//   combinational pixel-column decoder. It then registers the returned byte onto a
//   valid/ready stream, in horizontal addressing order and page by page.
//
// Ports
//   clk           system clock
//   resetn        asynchronous active-low reset
//   start         one-cycle pulse, begins a frame (ignored unless idle)
//   abort         abandons the frame in progress and returns to idle
//   digits_in     7 segment bits per digit, digit k at [7k+6:7k], digit 0 leftmost
//   dec_segments  segments of the digit currently being emitted
//   dec_index_x   column within the character cell
//   dec_index_y   page within the character cell
//   dec_pixels    pixel column returned by the decoder (combinational)
//   data_out      pixel byte towards the transport
//   data_valid    data_out holds a byte not yet accepted
//   data_ready    transport accepts data_out this cycle
//   busy          a frame is in progress
//   frame_done    one-cycle pulse after the last byte of a frame is accepted
module digit_column_streamer #(
  parameter int N_DIGITS = 8,
  parameter int CHAR_W   = 16,
  parameter int N_PAGES  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7*N_DIGITS-1:0] digits_in,
  output logic [6:0]            dec_segments,
  output logic [3:0]            dec_index_x,
  output logic [1:0]            dec_index_y,
  input  logic [7:0]            dec_pixels,
  output logic [7:0]            data_out,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [3:0]    COL_LAST   = 4'(CHAR_W - 1);
  localparam logic [DW-1:0] DIGIT_LAST = DW'(N_DIGITS - 1);
  localparam logic [1:0]    PAGE_LAST  = 2'(N_PAGES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    EMIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state_reg, state_next;
  logic [3:0]            col_reg, col_next;
  logic [DW-1:0]         digit_reg, digit_next;
  logic [1:0]            page_reg, page_next;
  logic [7*N_DIGITS-1:0] snap_reg;
  logic                  snap_en;
  logic [7:0]            data_out_reg, data_out_next;
  logic                  data_valid_reg, data_valid_next;
  logic                  busy_reg, busy_next;
  logic                  frame_done_reg, frame_done_next;
  logic                  load;

  // Output register is free to take a new byte when empty or being drained.
  assign load = !data_valid_reg || data_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      digit_reg      <= '0;
      page_reg       <= '0;
      snap_reg       <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      col_reg        <= col_next;
      digit_reg      <= digit_next;
      page_reg       <= page_next;
      data_out_reg   <= data_out_next;
      data_valid_reg <= data_valid_next;
      busy_reg       <= busy_next;
      frame_done_reg <= frame_done_next;
      if (snap_en) begin
        snap_reg <= digits_in;
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    col_next        = col_reg;
    digit_next      = digit_reg;
    page_next       = page_reg;
    data_out_next   = data_out_reg;
    data_valid_next = data_valid_reg;
    busy_next       = busy_reg;
    frame_done_next = 1'b0;
    snap_en         = 1'b0;

    case (state_reg)
      IDLE: begin
        // abort outranks start even while idle
        if (start && !abort) begin
          state_next = LOAD;
          busy_next  = 1'b1;
        end
      end
      LOAD: begin
        snap_en    = 1'b1;
        col_next   = '0;
        digit_next = '0;
        page_next  = '0;
        state_next = EMIT;
      end
      EMIT: begin
        if (load) begin
          data_out_next   = dec_pixels;
          data_valid_next = 1'b1;
          // col is innermost, then digit, then page; the page carry ends the frame
          if (col_reg == COL_LAST) begin
            col_next = '0;
            if (digit_reg == DIGIT_LAST) begin
              digit_next = '0;
              if (page_reg == PAGE_LAST) begin
                page_next  = '0;
                state_next = DRAIN;
              end else begin
                page_next = page_reg + 2'd1;
              end
            end else begin
              digit_next = digit_reg + DW'(1);
            end
          end else begin
            col_next = col_reg + 4'd1;
          end
        end
      end
      DRAIN: begin
        if (data_valid_reg && data_ready) begin
          data_valid_next = 1'b0;
          frame_done_next = 1'b1;
          busy_next       = 1'b0;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (abort && (state_reg != IDLE)) begin
      state_next      = IDLE;
      data_valid_next = 1'b0;
      busy_next       = 1'b0;
      frame_done_next = 1'b0;
      snap_en         = 1'b0;
    end
  end

  // Decoder drive is only meaningful while emitting; elsewhere it rests at zero.
  always_comb begin
    dec_segments = '0;
    dec_index_x  = '0;
    dec_index_y  = '0;
    if (state_reg == EMIT) begin
      dec_segments = snap_reg[7*int'(digit_reg) +: 7];
      dec_index_x  = col_reg;
      dec_index_y  = page_reg;
    end
  end

  assign data_out   = data_out_reg;
  assign data_valid = data_valid_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_digit_column_streamer.sv
// Testbench for digit_column_streamer: table of frame scenarios checked against a
// frame-level reference model, plus hand-written abort and reset sequences.
module tb_digit_column_streamer;

  localparam int ND     = 8;
  localparam int CW     = 16;
  localparam int NP     = 4;
  localparam int NBYTES = ND * CW * NP;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    string            name;
    logic [7*ND-1:0]  digits;
    int               ready_pct;
    bit               perturb;
    int               exp_bytes;
    int               exp_done;
    int               exp_latency;
  } vec_t;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic            data_ready = 1'b0;
  logic [7*ND-1:0] digits_in = '0;
  logic [6:0]      dec_segments;
  logic [3:0]      dec_index_x;
  logic [1:0]      dec_index_y;
  logic [7:0]      dec_pixels;
  logic [7:0]      data_out;
  logic            data_valid;
  logic            busy;
  logic            frame_done;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  digit_column_streamer #(.N_DIGITS(ND), .CHAR_W(CW), .N_PAGES(NP)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .abort       (abort),
    .digits_in   (digits_in),
    .dec_segments(dec_segments),
    .dec_index_x (dec_index_x),
    .dec_index_y (dec_index_y),
    .dec_pixels  (dec_pixels),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  // Stand-in for the 16x32 seven-segment pixel-column decoder.
  function automatic logic [7:0] seg_column(input logic [6:0] seg, input int x, input int y);
    logic [7:0] px;
    bit mid, right, left;
    px    = 8'h00;
    mid   = (x >= 2 && x <= 13);
    right = (x == 13 || x == 14);
    left  = (x == 1 || x == 2);
    if (seg[0] && mid && y == 0) px |= 8'h07;
    if (seg[1] && right) px |= (y == 0) ? 8'hF8 : (y == 1) ? 8'hFF : 8'h00;
    if (seg[2] && right) px |= (y == 2) ? 8'hFF : (y == 3) ? 8'h1F : 8'h00;
    if (seg[3] && mid && y == 3) px |= 8'hE0;
    if (seg[4] && left) px |= (y == 2) ? 8'hFF : (y == 3) ? 8'h1F : 8'h00;
    if (seg[5] && left) px |= (y == 0) ? 8'hF8 : (y == 1) ? 8'hFF : 8'h00;
    if (seg[6] && mid) px |= (y == 1) ? 8'h80 : (y == 2) ? 8'h01 : 8'h00;
    return px;
  endfunction

  always_comb dec_pixels = seg_column(dec_segments, int'(dec_index_x), int'(dec_index_y));

  // Reference: the full frame as the display should receive it.
  function automatic byte_q_t expected_frame(input logic [7*ND-1:0] dig);
    byte_q_t q;
    for (int p = 0; p < NP; p++)
      for (int d = 0; d < ND; d++)
        for (int c = 0; c < CW; c++)
          q.push_back(seg_column(dig[7*d +: 7], c, p));
    return q;
  endfunction

  task automatic check(input string name, input bit ok, input longint actual, input longint required);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, actual, required);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " data_out"},   data_out === 8'h00,   longint'(data_out),   0);
    check({tag, " data_valid"}, data_valid === 1'b0,  longint'(data_valid), 0);
    check({tag, " busy"},       busy === 1'b0,        longint'(busy),       0);
    check({tag, " frame_done"}, frame_done === 1'b0,  longint'(frame_done), 0);
    check({tag, " dec_all"}, {dec_segments, dec_index_x, dec_index_y} === 13'd0,
          longint'({dec_segments, dec_index_x, dec_index_y}), 0);
  endtask

  // Runs one frame from a start pulse; the task is entered just after a negedge.
  task automatic run_frame(input vec_t v);
    byte_q_t exp_q, got_q;
    int cyc = 0, first_valid = -1, done_cnt = 0, done_cyc = -1, last_xfer = -1;
    int hold_err = 0, mism = -1;
    bit stall = 1'b0, busy_at_done = 1'b1;
    logic [7:0] stall_data = 8'h00;
    longint act_b = 0, exp_b = 0;

    exp_q     = expected_frame(v.digits);
    digits_in = v.digits;
    start     = 1'b1;
    while (cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        check({v.name, " busy_in_load"}, busy === 1'b1, longint'(busy), 1);
      end
      if (v.perturb && cyc == 40) begin
        start     = 1'b1;
        digits_in = ~v.digits;
      end
      if (v.perturb && cyc == 41) start = 1'b0;
      if (v.perturb && cyc == 300) digits_in = {$urandom, $urandom};
      if (data_valid && first_valid < 0) first_valid = cyc;
      if (stall && !(data_valid === 1'b1 && data_out === stall_data)) hold_err++;
      if (frame_done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc     = cyc;
          busy_at_done = busy;
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      data_ready = ($urandom_range(99) < v.ready_pct);
      if (data_valid && data_ready) begin
        got_q.push_back(data_out);
        last_xfer = cyc;
      end
      stall      = data_valid && !data_ready;
      stall_data = data_out;
    end
    data_ready = 1'b0;

    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        mism  = i;
        act_b = longint'(got_q[i]);
        exp_b = longint'(exp_q[i]);
        break;
      end
    end
    check({v.name, " latency"}, first_valid == v.exp_latency, first_valid, v.exp_latency);
    check({v.name, " byte_count"}, got_q.size() == v.exp_bytes, got_q.size(), v.exp_bytes);
    check({v.name, " byte_values"}, mism < 0, act_b, exp_b);
    check({v.name, " hold_while_stalled"}, hold_err == 0, hold_err, 0);
    check({v.name, " done_pulses"}, done_cnt == v.exp_done, done_cnt, v.exp_done);
    check({v.name, " done_timing"}, done_cyc >= 0 && done_cyc == last_xfer + 1, done_cyc, last_xfer + 1);
    check({v.name, " busy_low_at_done"}, busy_at_done == 1'b0, longint'(busy_at_done), 0);
    $display("frame %s: %0d bytes, first mismatch index %0d, done at cycle %0d",
             v.name, got_q.size(), mism, done_cyc);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t v;
    int n;
    bit reached, done_seen;

    vecs[0] = '{"all8_full",    {ND{7'h7F}},         100, 1'b0, NBYTES, 1, 3};
    vecs[1] = '{"blank_full",   '0,                  100, 1'b0, NBYTES, 1, 3};
    vecs[2] = '{"all8_bp50",    {ND{7'h7F}},          50, 1'b0, NBYTES, 1, 3};
    vecs[3] = '{"perturbed",    {$urandom, $urandom}, 60, 1'b1, NBYTES, 1, 3};
    vecs[4] = '{"random_bp50",  {$urandom, $urandom}, 50, 1'b0, NBYTES, 1, 3};
    vecs[5] = '{"random_full",  {$urandom, $urandom},100, 1'b0, NBYTES, 1, 3};

    // Reset state
    #2;
    check_idle_outputs("reset");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    check_idle_outputs("idle_no_start");

    // abort together with start in idle: start is ignored
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_beats_start busy", busy === 1'b0, longint'(busy), 0);
    repeat (3) @(negedge clk);
    check("abort_beats_start valid", data_valid === 1'b0, longint'(data_valid), 0);

    foreach (vecs[i]) run_frame(vecs[i]);

    // Abort while byte 100 is valid and stalled
    digits_in  = {$urandom, $urandom};
    start      = 1'b1;
    data_ready = 1'b1;
    n          = 0;
    reached    = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (data_valid && n == 100) begin
        reached = 1'b1;
        break;
      end
      if (data_valid && data_ready) n++;
    end
    check("abort reached_byte_100", reached, n, 100);
    data_ready = 1'b0;
    abort      = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort valid_low", data_valid === 1'b0, longint'(data_valid), 0);
    check("abort busy_low", busy === 1'b0, longint'(busy), 0);
    done_seen = (frame_done === 1'b1);
    repeat (4) begin
      @(negedge clk);
      if (frame_done === 1'b1 || data_valid === 1'b1) done_seen = 1'b1;
    end
    check("abort no_done_or_valid", done_seen == 1'b0, longint'(done_seen), 0);
    v = '{"after_abort", {$urandom, $urandom}, 70, 1'b0, NBYTES, 1, 3};
    run_frame(v);

    // Reset asserted mid-frame
    digits_in  = {$urandom, $urandom};
    start      = 1'b1;
    data_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("midreset frame_running", data_valid === 1'b1, longint'(data_valid), 1);
    #2 resetn = 1'b0;
    #1;
    check_idle_outputs("midreset_async");
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(negedge clk);
    check_idle_outputs("after_reset_idle");
    data_ready = 1'b0;
    v = '{"after_reset", {$urandom, $urandom}, 100, 1'b0, NBYTES, 1, 3};
    run_frame(v);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
